// File: rtl/occupancy_pkg.sv
// Shared types for the multi-gate parking occupancy tracker.
package occupancy_pkg;

    // Direction FSM state for one gate: EN* walks an entry, EX* walks an exit.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } gate_state_e;

    // Synchronised sensor pair, ordered {outer, inner}.
    localparam logic [1:0] S_NONE  = 2'b00;
    localparam logic [1:0] S_INNER = 2'b01;
    localparam logic [1:0] S_OUTER = 2'b10;
    localparam logic [1:0] S_BOTH  = 2'b11;

endpackage

// File: rtl/gate_fsm.sv
// One gate: synchronises the outer/inner beam sensors and tracks the direction
// of a passing car, emitting a registered one-cycle pulse per completed passage.
module gate_fsm
    import occupancy_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic outer,
    input  logic inner,
    output logic enter_pulse,
    output logic exit_pulse
);

    logic [SYNC_STAGES-1:0] outer_sync_r;
    logic [SYNC_STAGES-1:0] inner_sync_r;
    logic [1:0]             sens_s;
    gate_state_e            state_r;
    gate_state_e            state_next_s;
    logic                   enter_s;
    logic                   exit_s;
    logic                   enter_r;
    logic                   exit_r;

    // Multi-flop synchroniser chains for the asynchronous sensor inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outer_sync_r <= '0;
            inner_sync_r <= '0;
        end else begin
            outer_sync_r <= {outer_sync_r[SYNC_STAGES-2:0], outer};
            inner_sync_r <= {inner_sync_r[SYNC_STAGES-2:0], inner};
        end
    end

    assign sens_s = {outer_sync_r[SYNC_STAGES-1], inner_sync_r[SYNC_STAGES-1]};

    // State register plus registered passage pulses (updated on the same edge).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            enter_r <= 1'b0;
            exit_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            enter_r <= enter_s;
            exit_r  <= exit_s;
        end
    end

    // Next-state decode; any pattern that breaks the beam order drops back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                case (sens_s)
                    S_OUTER: state_next_s = EN1;
                    S_INNER: state_next_s = EX1;
                    default: state_next_s = IDLE;
                endcase
            end
            EN1: begin
                case (sens_s)
                    S_BOTH:  state_next_s = EN2;
                    S_OUTER: state_next_s = EN1;
                    default: state_next_s = IDLE;
                endcase
            end
            EN2: begin
                case (sens_s)
                    S_INNER: state_next_s = EN3;
                    S_OUTER: state_next_s = EN1;
                    S_BOTH:  state_next_s = EN2;
                    default: state_next_s = IDLE;
                endcase
            end
            EN3: begin
                case (sens_s)
                    S_BOTH:  state_next_s = EN2;
                    S_INNER: state_next_s = EN3;
                    default: state_next_s = IDLE;
                endcase
            end
            EX1: begin
                case (sens_s)
                    S_BOTH:  state_next_s = EX2;
                    S_INNER: state_next_s = EX1;
                    default: state_next_s = IDLE;
                endcase
            end
            EX2: begin
                case (sens_s)
                    S_OUTER: state_next_s = EX3;
                    S_INNER: state_next_s = EX1;
                    S_BOTH:  state_next_s = EX2;
                    default: state_next_s = IDLE;
                endcase
            end
            EX3: begin
                case (sens_s)
                    S_BOTH:  state_next_s = EX2;
                    S_OUTER: state_next_s = EX3;
                    default: state_next_s = IDLE;
                endcase
            end
            default: state_next_s = IDLE;
        endcase
    end

    // A passage completes when the last beam clears from the final stage.
    always_comb begin
        enter_s = (state_r == EN3) && (sens_s == S_NONE);
        exit_s  = (state_r == EX3) && (sens_s == S_NONE);
    end

    assign enter_pulse = enter_r;
    assign exit_pulse  = exit_r;

endmodule

// File: rtl/multi_gate_occupancy.sv
// Parking-lot occupancy tracker: one direction FSM per gate feeding a shared
// saturating counter with full/empty flags and sticky overflow/underflow errors.
module multi_gate_occupancy
    import occupancy_pkg::*;
#(
    parameter int NUM_GATES   = 2,
    parameter int CAPACITY    = 25,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_GATES-1:0] outer,
    input  logic [NUM_GATES-1:0] inner,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] enter_pulse,
    output logic [NUM_GATES-1:0] exit_pulse,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    // Wide enough to hold occupancy plus every gate entering, with a sign bit.
    localparam int SUM_W = CNT_W + $clog2(NUM_GATES + 1) + 1;
    localparam logic signed [SUM_W-1:0] CAP_S  = SUM_W'(CAPACITY);
    localparam logic signed [SUM_W-1:0] ZERO_S = SUM_W'(0);
    localparam logic [CNT_W-1:0]        CAP_C  = CNT_W'(CAPACITY);

    logic [NUM_GATES-1:0]    gate_enter_s;
    logic [NUM_GATES-1:0]    gate_exit_s;
    logic signed [SUM_W-1:0] n_in_s;
    logic signed [SUM_W-1:0] n_out_s;
    logic signed [SUM_W-1:0] next_s;
    logic [CNT_W-1:0]        occ_next_s;
    logic                    ovf_s;
    logic                    unf_s;
    logic [CNT_W-1:0]        occupancy_r;
    logic                    full_r;
    logic                    empty_r;
    logic                    overflow_err_r;
    logic                    underflow_err_r;

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_fsm #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gate_fsm (
            .clk         (clk),
            .reset_n     (reset_n),
            .outer       (outer[g]),
            .inner       (inner[g]),
            .enter_pulse (gate_enter_s[g]),
            .exit_pulse  (gate_exit_s[g])
        );
    end

    // Net all gate pulses first, then saturate against 0 and CAPACITY.
    always_comb begin
        n_in_s  = ZERO_S;
        n_out_s = ZERO_S;
        for (int g = 0; g < NUM_GATES; g++) begin
            n_in_s  = n_in_s  + $signed(SUM_W'(gate_enter_s[g]));
            n_out_s = n_out_s + $signed(SUM_W'(gate_exit_s[g]));
        end
        next_s = $signed(SUM_W'(occupancy_r)) + n_in_s - n_out_s;
        if (next_s > CAP_S) begin
            occ_next_s = CAP_C;
            ovf_s      = 1'b1;
            unf_s      = 1'b0;
        end else if (next_s < ZERO_S) begin
            occ_next_s = '0;
            ovf_s      = 1'b0;
            unf_s      = 1'b1;
        end else begin
            occ_next_s = next_s[CNT_W-1:0];
            ovf_s      = 1'b0;
            unf_s      = 1'b0;
        end
    end

    // Count, flags derived from the new count, and sticky errors (a new error beats clear_err).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy_r     <= '0;
            full_r          <= 1'b0;
            empty_r         <= 1'b1;
            overflow_err_r  <= 1'b0;
            underflow_err_r <= 1'b0;
        end else begin
            occupancy_r     <= occ_next_s;
            full_r          <= (occ_next_s == CAP_C);
            empty_r         <= (occ_next_s == '0);
            overflow_err_r  <= ovf_s | (overflow_err_r  & ~clear_err);
            underflow_err_r <= unf_s | (underflow_err_r & ~clear_err);
        end
    end

    assign occupancy     = occupancy_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign enter_pulse   = gate_enter_s;
    assign exit_pulse    = gate_exit_s;
    assign overflow_err  = overflow_err_r;
    assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_multi_gate_occupancy.sv
// Scoreboard bench: two trackers (capacity 25 and 3) share the same sensors;
// expected pulses are queued as stimulus is driven and popped when pulses appear.
module tb_multi_gate_occupancy;

    localparam int CAP_A = 25;
    localparam int CAP_B = 3;

    typedef struct packed {
        logic [1:0] en;
        logic [1:0] ex;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] outer;
    logic [1:0] inner;
    logic       clear_err;
    logic       main_clear;
    logic       mon_clear;

    logic [4:0] occ_a;
    logic       full_a, empty_a, ovf_a, unf_a;
    logic [1:0] en_a, ex_a;
    logic [1:0] occ_b;
    logic       full_b, empty_b, ovf_b, unf_b;
    logic [1:0] en_b, ex_b;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   m_occ_a, m_occ_b;
    bit   m_ovf_a, m_unf_a, m_ovf_b, m_unf_b;
    bit   clr_with_pulse;

    assign clear_err = main_clear | mon_clear;

    always #5 clk = ~clk;

    multi_gate_occupancy #(
        .NUM_GATES (2), .CAPACITY (CAP_A), .SYNC_STAGES (2)
    ) u_dut_a (
        .clk (clk), .reset_n (reset_n), .outer (outer), .inner (inner),
        .clear_err (clear_err), .occupancy (occ_a), .full (full_a), .empty (empty_a),
        .enter_pulse (en_a), .exit_pulse (ex_a),
        .overflow_err (ovf_a), .underflow_err (unf_a)
    );

    multi_gate_occupancy #(
        .NUM_GATES (2), .CAPACITY (CAP_B), .SYNC_STAGES (2)
    ) u_dut_b (
        .clk (clk), .reset_n (reset_n), .outer (outer), .inner (inner),
        .clear_err (clear_err), .occupancy (occ_b), .full (full_b), .empty (empty_b),
        .enter_pulse (en_b), .exit_pulse (ex_b),
        .overflow_err (ovf_b), .underflow_err (unf_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_step(inout int occ, inout bit ovf, inout bit unf,
                              input int cap, input int net);
        int t;
        t = occ + net;
        if (t > cap) begin
            occ = cap;
            ovf = 1'b1;
        end else if (t < 0) begin
            occ = 0;
            unf = 1'b1;
        end else begin
            occ = t;
        end
    endtask

    task automatic model_reset();
        m_occ_a = 0; m_occ_b = 0;
        m_ovf_a = 1'b0; m_unf_a = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
    endtask

    task automatic check_flags(input string where);
        check_eq({where, "_occ_a"},   occ_a,   m_occ_a);
        check_eq({where, "_full_a"},  full_a,  m_occ_a == CAP_A);
        check_eq({where, "_empty_a"}, empty_a, m_occ_a == 0);
        check_eq({where, "_ovf_a"},   ovf_a,   m_ovf_a);
        check_eq({where, "_unf_a"},   unf_a,   m_unf_a);
        check_eq({where, "_occ_b"},   occ_b,   m_occ_b);
        check_eq({where, "_full_b"},  full_b,  m_occ_b == CAP_B);
        check_eq({where, "_empty_b"}, empty_b, m_occ_b == 0);
        check_eq({where, "_ovf_b"},   ovf_b,   m_ovf_b);
        check_eq({where, "_unf_b"},   unf_b,   m_unf_b);
    endtask

    // Pops one expected event per observed pulse and checks the count one cycle later.
    task automatic monitor();
        exp_t e;
        int   net;
        bit   pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending   = 1'b0;
                mon_clear = 1'b0;
                check_flags("post_pulse");
            end
            if (reset_n === 1'b1 && (|{en_a, ex_a, en_b, ex_b})) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", {24'd0, en_a, ex_a, en_b, ex_b}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("enter_a", en_a, e.en);
                    check_eq("exit_a",  ex_a, e.ex);
                    check_eq("enter_b", en_b, e.en);
                    check_eq("exit_b",  ex_b, e.ex);
                    if (clr_with_pulse) begin
                        mon_clear = 1'b1;
                        m_ovf_a = 1'b0; m_unf_a = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
                    end
                    net = $countones(e.en) - $countones(e.ex);
                    model_step(m_occ_a, m_ovf_a, m_unf_a, CAP_A, net);
                    model_step(m_occ_b, m_ovf_b, m_unf_b, CAP_B, net);
                    pending = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_step(input logic [1:0] g0, input logic [1:0] g1);
        outer = {g1[1], g0[1]};
        inner = {g1[0], g0[0]};
        repeat (4) @(negedge clk);
    endtask

    // Each step is {outer,inner}; four steps per gate, each held four cycles.
    task automatic run_seq(input logic [7:0] g0s, input logic [7:0] g1s,
                           input logic [1:0] en, input logic [1:0] ex, input bit clr);
        exp_t e;
        if ((en | ex) != 2'b00) begin
            e.en = en;
            e.ex = ex;
            exp_q.push_back(e);
        end
        clr_with_pulse = clr;
        for (int i = 0; i < 4; i++) begin
            drive_step(g0s[7-2*i -: 2], g1s[7-2*i -: 2]);
        end
        repeat (4) @(negedge clk);
        check_eq("pulse_seen", exp_q.size(), 0);
        exp_q.delete();
        clr_with_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        main_clear = 1'b1;
        @(negedge clk);
        main_clear = 1'b0;
        m_ovf_a = 1'b0; m_unf_a = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
        check_flags("clear");
    endtask

    initial begin
        reset_n = 1'b0;
        outer = 2'b00;
        inner = 2'b00;
        main_clear = 1'b0;
        mon_clear = 1'b0;
        clr_with_pulse = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_flags("reset");
        check_eq("reset_pulses", {28'd0, en_a, ex_a}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single entry at gate 0: 0 -> 1, empty drops.
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b0);
        // Two more entries to reach 3 (capacity-3 tracker becomes full).
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b0);
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b0);
        // Exit at gate 1: 3 -> 2.
        run_seq(8'b00_00_00_00, 8'b01_11_10_00, 2'b00, 2'b10, 1'b0);
        // Gate 1 starts an entry then backs out: no pulse.
        run_seq(8'b00_00_00_00, 8'b10_11_10_00, 2'b00, 2'b00, 1'b0);
        // Gate 0 backs out, then a bare outer blip: no pulses.
        run_seq(8'b10_11_10_00, 8'b00_00_00_00, 2'b00, 2'b00, 1'b0);
        run_seq(8'b10_00_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 1'b0);
        check_flags("no_pulse_hold");

        // Fill the capacity-3 tracker and push one past it.
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b0);
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b0);
        pulse_clear();
        // Overflow coinciding with clear_err: the new error must stick.
        run_seq(8'b10_11_01_00, 8'b00_00_00_00, 2'b01, 2'b00, 1'b1);
        pulse_clear();
        // Simultaneous entry (gate 0) and exit (gate 1) at 5 and at capacity: no change.
        run_seq(8'b10_11_01_00, 8'b01_11_10_00, 2'b01, 2'b10, 1'b0);

        // Reset while gate 0 sits mid-entry.
        drive_step(2'b10, 2'b00);
        drive_step(2'b11, 2'b00);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_flags("mid_reset");
        outer = 2'b00;
        inner = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        // Finishing the old entry pattern from IDLE must not produce a pulse.
        drive_step(2'b11, 2'b00);
        drive_step(2'b01, 2'b00);
        drive_step(2'b00, 2'b00);
        drive_step(2'b00, 2'b00);
        check_flags("after_reset");

        // Exit from empty: count stays 0, underflow flagged.
        run_seq(8'b01_11_10_00, 8'b00_00_00_00, 2'b00, 2'b01, 1'b0);
        pulse_clear();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
